// File: rtl/eit_dds_sample_source.sv
// DDS sine source for the EIT excitation DAC: phase accumulator, quarter-wave ROM, amplitude scale, differential offset-binary pair.
// Latency: 3 sysclk cycles from the tick cycle to the data_ready_o strobe; ticks every sample_div+1 cycles (minimum 4).
// Backpressure: a tick that meets dac_busy_i=1 is dropped (phase still advances) and sets sticky overrun_o; the park strobe waits for dac_busy_i=0.
module eit_dds_sample_source #(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int DATA_W  = 16,
    parameter int DIV_W   = 16
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic [PHASE_W-1:0] freq_word_i,
    input  logic [DIV_W-1:0]   sample_div_i,
    input  logic [DATA_W-1:0]  amp_i,
    input  logic               dac_busy_i,
    output logic               data_ready_o,
    output logic [DATA_W-1:0]  sample_a_o,
    output logic [DATA_W-1:0]  sample_b_o,
    output logic               overrun_o,
    output logic [31:0]        sample_cnt_o
);

    localparam int ROM_N = 1 << LUT_AW;
    // ROM holds the positive quarter wave magnitude; sign comes from the quadrant.
    localparam int LUT_W = DATA_W - 1;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DIV_W-1:0]  DIV_MIN  = DIV_W'(3);

    // Build lut[k] = round((2^(DATA_W-1)-1) * sin(pi/2 * (k+0.5)/ROM_N)) at elaboration
    // using Q60 fixed point and a Taylor series; x < pi/2 so 12 terms are far beyond 1 LSB.
    function automatic logic [ROM_N*LUT_W-1:0] build_lut();
        logic [ROM_N*LUT_W-1:0] rom;
        logic signed [127:0]    pi_q;
        logic signed [127:0]    x;
        logic signed [127:0]    x2;
        logic signed [127:0]    term;
        logic signed [127:0]    acc;
        logic signed [127:0]    den;
        logic signed [127:0]    val;
        rom  = '0;
        pi_q = 128'sh3243F6A8885A308D;
        for (int k = 0; k < ROM_N; k++) begin
            x    = (pi_q * 128'(2 * k + 1)) / 128'(4 * ROM_N);
            x2   = (x * x) >>> 60;
            term = x;
            acc  = x;
            for (int n = 1; n <= 12; n++) begin
                den  = 128'((2 * n) * (2 * n + 1));
                term = (term * x2) >>> 60;
                term = -(term / den);
                acc  = acc + term;
            end
            val = (acc * 128'((1 << LUT_W) - 1) + (128'sd1 <<< 59)) >>> 60;
            rom[k*LUT_W +: LUT_W] = LUT_W'(val);
        end
        return rom;
    endfunction

    localparam logic [ROM_N*LUT_W-1:0] LUT_ROM = build_lut();

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_LOOKUP,
        ST_SCALE,
        ST_PRESENT,
        ST_PARK
    } state_t;

    state_t                    state_q,      state_d;
    logic [DIV_W-1:0]          div_q,        div_d;
    logic [DIV_W-1:0]          tick_cnt_q,   tick_cnt_d;
    logic [PHASE_W-1:0]        phase_q,      phase_d;
    logic [LUT_AW+1:0]         phase_top_q,  phase_top_d;
    logic [DATA_W-1:0]         amp_q,        amp_d;
    logic [LUT_W-1:0]          rom_q,        rom_d;
    logic                      neg_q,        neg_d;
    logic [DATA_W-1:0]         scaled_q,     scaled_d;
    logic [DATA_W-1:0]         sample_a_q,   sample_a_d;
    logic [DATA_W-1:0]         sample_b_q,   sample_b_d;
    logic                      data_ready_q, data_ready_d;
    logic                      overrun_q,    overrun_d;
    logic [31:0]               sample_cnt_q, sample_cnt_d;

    logic                      tick;
    logic [LUT_AW-1:0]         rom_addr;
    logic signed [DATA_W:0]    val_s;
    logic signed [2*DATA_W+1:0] val_x;
    logic signed [2*DATA_W+1:0] amp_x;

    // Next-state logic: sample clock, phase accumulation, lookup/scale/present pipeline and park.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        tick_cnt_d   = tick_cnt_q;
        phase_d      = phase_q;
        phase_top_d  = phase_top_q;
        amp_d        = amp_q;
        rom_d        = rom_q;
        neg_d        = neg_q;
        scaled_d     = scaled_q;
        sample_a_d   = sample_a_q;
        sample_b_d   = sample_b_q;
        data_ready_d = 1'b0;
        overrun_d    = overrun_q;
        sample_cnt_d = sample_cnt_q;

        tick = (state_q != ST_IDLE) && (state_q != ST_PARK) && (tick_cnt_q == div_q);

        // Odd quadrants run the quarter wave backwards: 255-idx is just ~idx.
        rom_addr = phase_top_q[LUT_AW] ? ~phase_top_q[LUT_AW-1:0] : phase_top_q[LUT_AW-1:0];

        val_s = neg_q ? -$signed({2'b00, rom_q}) : $signed({2'b00, rom_q});
        val_x = {{(DATA_W+1){val_s[DATA_W]}}, val_s};
        amp_x = $signed({{(DATA_W+2){1'b0}}, amp_q});

        // Sample-rate counter free-runs over 0..div while the source is active.
        if ((state_q != ST_IDLE) && (state_q != ST_PARK)) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d      = ST_RUN;
                    div_d        = (sample_div_i < DIV_MIN) ? DIV_MIN : sample_div_i;
                    tick_cnt_d   = '0;
                    phase_d      = '0;
                    overrun_d    = 1'b0;
                    sample_cnt_d = '0;
                end
            end
            ST_RUN, ST_LOOKUP, ST_SCALE, ST_PRESENT: begin
                // Disable wins over everything in flight, including a coincident tick,
                // so the park strobe can never sit right behind a sample strobe.
                if (!enable_i) begin
                    state_d = ST_PARK;
                end else begin
                    case (state_q)
                        ST_RUN: begin
                            if (tick) begin
                                amp_d   = amp_i;
                                phase_d = phase_q + freq_word_i;
                                if (dac_busy_i) begin
                                    overrun_d = 1'b1;
                                end else begin
                                    phase_top_d = phase_q[PHASE_W-1 -: LUT_AW+2];
                                    state_d     = ST_LOOKUP;
                                end
                            end
                        end
                        ST_LOOKUP: begin
                            rom_d   = LUT_ROM[int'(rom_addr) * LUT_W +: LUT_W];
                            neg_d   = phase_top_q[LUT_AW+1];
                            state_d = ST_SCALE;
                        end
                        ST_SCALE: begin
                            scaled_d = DATA_W'((val_x * amp_x) >>> DATA_W);
                            state_d  = ST_PRESENT;
                        end
                        default: begin
                            sample_a_d   = MIDSCALE + scaled_q;
                            sample_b_d   = MIDSCALE - scaled_q;
                            data_ready_d = 1'b1;
                            sample_cnt_d = sample_cnt_q + 32'd1;
                            state_d      = ST_RUN;
                        end
                    endcase
                end
            end
            ST_PARK: begin
                if (!dac_busy_i) begin
                    sample_a_d   = MIDSCALE;
                    sample_b_d   = MIDSCALE;
                    data_ready_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset drops any sample in flight.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_q        <= DIV_MIN;
            tick_cnt_q   <= '0;
            phase_q      <= '0;
            phase_top_q  <= '0;
            amp_q        <= '0;
            rom_q        <= '0;
            neg_q        <= 1'b0;
            scaled_q     <= '0;
            sample_a_q   <= MIDSCALE;
            sample_b_q   <= MIDSCALE;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            tick_cnt_q   <= tick_cnt_d;
            phase_q      <= phase_d;
            phase_top_q  <= phase_top_d;
            amp_q        <= amp_d;
            rom_q        <= rom_d;
            neg_q        <= neg_d;
            scaled_q     <= scaled_d;
            sample_a_q   <= sample_a_d;
            sample_b_q   <= sample_b_d;
            data_ready_q <= data_ready_d;
            overrun_q    <= overrun_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign data_ready_o = data_ready_q;
    assign sample_a_o   = sample_a_q;
    assign sample_b_o   = sample_b_q;
    assign overrun_o    = overrun_q;
    assign sample_cnt_o = sample_cnt_q;

endmodule

// File: tb/tb_eit_dds_sample_source.sv
// Bench for eit_dds_sample_source: directed runs push expected strobes (values, count, cycle)
// into a queue; a negedge monitor pops and compares on every data_ready_o.
module tb_eit_dds_sample_source;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic [23:0] freq_word_i = '0;
    logic [15:0] sample_div_i = '0;
    logic [15:0] amp_i = '0;
    logic        dac_busy_i = 1'b0;
    logic        data_ready_o;
    logic [15:0] sample_a_o;
    logic [15:0] sample_b_o;
    logic        overrun_o;
    logic [31:0] sample_cnt_o;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          cnt;
        int          at;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_rdy = 1'b0;

    eit_dds_sample_source #(
        .PHASE_W(24),
        .LUT_AW (8),
        .DATA_W (16),
        .DIV_W  (16)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .enable_i    (enable_i),
        .freq_word_i (freq_word_i),
        .sample_div_i(sample_div_i),
        .amp_i       (amp_i),
        .dac_busy_i  (dac_busy_i),
        .data_ready_o(data_ready_o),
        .sample_a_o  (sample_a_o),
        .sample_b_o  (sample_b_o),
        .overrun_o   (overrun_o),
        .sample_cnt_o(sample_cnt_o)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_smp(input logic [15:0] a, input logic [15:0] b, input int cnt, input int at);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.cnt = cnt;
        e.at  = at;
        sb_q.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge sysclk);
    endtask

    // Called on a negedge; the enable edge is the following posedge.
    task automatic start_run(input logic [15:0] div, input logic [15:0] amp, output int c0);
        enable_i     = 1'b1;
        sample_div_i = div;
        freq_word_i  = 24'h400000;
        amp_i        = amp;
        c0           = cyc;
    endtask

    // Scoreboard monitor: every strobe must match the head of the expected queue.
    always @(negedge sysclk) begin
        if (data_ready_o === 1'b1) begin
            chk("strobe_not_back_to_back", 64'(prev_rdy), 64'(0));
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe a=0x%0h b=0x%0h, expected none (cycle %0d)",
                         sample_a_o, sample_b_o, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("strobe_cycle", 64'(cyc), 64'(e.at));
                chk("sample_a", 64'(sample_a_o), 64'(e.a));
                chk("sample_b", 64'(sample_b_o), 64'(e.b));
                chk("sample_cnt", 64'(sample_cnt_o), 64'(e.cnt));
            end
        end
        prev_rdy <= (data_ready_o === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;

        // Reset and idle state.
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        chk("rst_data_ready", 64'(data_ready_o), 64'(0));
        chk("rst_sample_a", 64'(sample_a_o), 64'h8000);
        chk("rst_sample_b", 64'(sample_b_o), 64'h8000);
        chk("rst_overrun", 64'(overrun_o), 64'(0));
        chk("rst_sample_cnt", 64'(sample_cnt_o), 64'(0));
        wait_until(cyc + 3);
        chk("idle_data_ready", 64'(data_ready_o), 64'(0));

        // Full scale, div 9: four quadrants, then park with DAC idle.
        start_run(16'd9, 16'hFFFF, c0);
        expect_smp(16'h8064, 16'h7F9C, 1, c0 + 14);
        expect_smp(16'hFFFE, 16'h0002, 2, c0 + 24);
        expect_smp(16'h7F9B, 16'h8065, 3, c0 + 34);
        expect_smp(16'h0001, 16'hFFFF, 4, c0 + 44);
        expect_smp(16'h8000, 16'h8000, 4, c0 + 48);
        wait_until(c0 + 5);
        sample_div_i = 16'd20;
        wait_until(c0 + 46);
        enable_i = 1'b0;
        wait_until(c0 + 52);
        chk("cnt_held_after_park", 64'(sample_cnt_o), 64'(4));

        // Half amplitude: s = 50 then 16383.
        start_run(16'd9, 16'h8000, c0);
        expect_smp(16'h8032, 16'h7FCE, 1, c0 + 14);
        expect_smp(16'hBFFF, 16'h4001, 2, c0 + 24);
        expect_smp(16'h8000, 16'h8000, 2, c0 + 28);
        wait_until(c0 + 26);
        enable_i = 1'b0;
        wait_until(c0 + 32);

        // Divider 0 clamps to 3 (period 4); disable during LOOKUP aborts the third sample.
        start_run(16'd0, 16'hFFFF, c0);
        expect_smp(16'h8064, 16'h7F9C, 1, c0 + 8);
        expect_smp(16'hFFFE, 16'h0002, 2, c0 + 12);
        expect_smp(16'h8000, 16'h8000, 2, c0 + 15);
        wait_until(c0 + 13);
        enable_i = 1'b0;
        wait_until(c0 + 20);

        // Busy across the 2nd tick: dropped, overrun set, phase keeps going (q2 next).
        // Then disable while busy: park strobe waits for busy to drop.
        start_run(16'd9, 16'hFFFF, c0);
        expect_smp(16'h8064, 16'h7F9C, 1, c0 + 14);
        expect_smp(16'h7F9B, 16'h8065, 2, c0 + 34);
        expect_smp(16'h8000, 16'h8000, 2, c0 + 42);
        wait_until(c0 + 18);
        dac_busy_i = 1'b1;
        wait_until(c0 + 20);
        chk("overrun_before_drop", 64'(overrun_o), 64'(0));
        wait_until(c0 + 23);
        dac_busy_i = 1'b0;
        wait_until(c0 + 25);
        chk("overrun_after_drop", 64'(overrun_o), 64'(1));
        wait_until(c0 + 36);
        dac_busy_i = 1'b1;
        enable_i   = 1'b0;
        wait_until(c0 + 41);
        dac_busy_i = 1'b0;
        wait_until(c0 + 45);
        chk("overrun_sticky_after_park", 64'(overrun_o), 64'(1));

        // Re-enable clears overrun; reset during SCALE kills the in-flight sample.
        start_run(16'd9, 16'hFFFF, c0);
        expect_smp(16'h8064, 16'h7F9C, 1, c0 + 14);
        wait_until(c0 + 2);
        chk("overrun_cleared_on_enable", 64'(overrun_o), 64'(0));
        wait_until(c0 + 22);
        reset    = 1'b1;
        enable_i = 1'b0;
        wait_until(c0 + 23);
        reset = 1'b0;
        wait_until(c0 + 26);
        chk("midrst_data_ready", 64'(data_ready_o), 64'(0));
        chk("midrst_sample_a", 64'(sample_a_o), 64'h8000);
        chk("midrst_sample_b", 64'(sample_b_o), 64'h8000);
        chk("midrst_sample_cnt", 64'(sample_cnt_o), 64'(0));
        chk("midrst_overrun", 64'(overrun_o), 64'(0));
        wait_until(c0 + 50);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eit_dds_sample_source.md
Name: eit_dds_sample_source

Overview:
- Upstream stage of the serial DAC block in the EIT excitation chain.
- Generates a digitally synthesized sine (phase accumulator plus quarter-wave ROM) at a programmable sample rate and applies amplitude scaling.
- Presents a differential sample pair (A = +sine, B = -sine, offset binary) with a one-cycle data_ready_o strobe; this strobe drives the DAC block's data_ready_i.
- Handles DAC back-pressure, overrun flagging and a safe midscale park on disable.

Parameters:
- PHASE_W, 24, phase accumulator width; freq_word_i width.
- LUT_AW, 8, quarter-wave ROM address width (256 entries).
- DATA_W, 16, sample width.
- DIV_W, 16, sample-rate divider width.

Ports:
- sysclk, in, 1, system clock. All logic is on its rising edge.
- reset, in, 1, synchronous active-high reset.
- enable_i, in, 1, level. High = run, low = stop and park.
- freq_word_i, in, PHASE_W, phase increment per sample.
- sample_div_i, in, DIV_W, sample period minus 1, in sysclk cycles.
- amp_i, in, DATA_W, unsigned Q0.16 amplitude (0xFFFF ≈ 1.0).
- dac_busy_i, in, 1, high while the downstream DAC is shifting a frame.
- data_ready_o, out, 1, one-cycle strobe: new sample pair valid.
- sample_a_o, out, DATA_W, offset-binary +sine.
- sample_b_o, out, DATA_W, offset-binary -sine.
- overrun_o, out, 1, sticky: a tick was dropped because the DAC was busy.
- sample_cnt_o, out, 32, samples issued since enable rose (wraps).

Behaviour:
- Reset values:
  - data_ready_o = 0, overrun_o = 0, sample_cnt_o = 0.
  - sample_a_o = sample_b_o = 0x8000.
  - Phase accumulator = 0, tick counter = 0, state = IDLE.
- Reset mid-operation: any in-flight sample is discarded and no strobe is issued.
- On enable_i rising:
  - Latch sample_div_i, clamping values below 3 to 3; changes while running are ignored.
  - Clear phase, tick counter, overrun_o and sample_cnt_o.
- Tick counter: counts 0..div_latched. The tick fires on the cycle it equals div_latched, then it wraps to 0. The first tick comes div_latched+1 cycles after the enable edge.
- freq_word_i and amp_i are sampled on each tick.
- State machine:
  - IDLE: leave when enable_i = 1 → RUN.
  - RUN, tick with dac_busy_i = 0 → LOOKUP. Register the current phase, then phase += freq_word (mod 2^PHASE_W).
  - RUN, tick with dac_busy_i = 1 → stay in RUN. Set overrun_o, no strobe; the phase still advances so the frequency is preserved.
  - LOOKUP (1 cycle): registered ROM read → SCALE.
  - SCALE (1 cycle): signed multiply → PRESENT.
  - PRESENT (1 cycle): update outputs, data_ready_o = 1, sample_cnt_o += 1 → RUN.
  - Latency from tick cycle to strobe: 3 cycles.
- Quadrant mapping, with q = phase[PW-1:PW-2] and idx = phase[PW-3:PW-2-LUT_AW]:
  - q0: +lut[idx].
  - q1: +lut[255-idx].
  - q2: -lut[idx].
  - q3: -lut[255-idx].
- ROM contents: lut[k] = round(32767 * sin(pi/2 * (k+0.5)/256)), so lut[0] = 101 and lut[255] = 32767.
- Scaling: s = (signed17 value * unsigned amp) >>> 16, an arithmetic shift that floors.
- Output encoding: sample_a_o = 0x8000 + s and sample_b_o = 0x8000 - s, both mod 2^16. Range is guaranteed with no saturation needed.
- Outputs hold between strobes. data_ready_o is never high on two consecutive cycles.
- On enable_i falling (any state except IDLE):
  - Abort any pending LOOKUP/SCALE.
  - Enter PARK: wait for dac_busy_i = 0, then drive both outputs to 0x8000 with one strobe → IDLE.
  - If enable_i rises again while in PARK, the park strobe is still issued first, then the block re-enters RUN via the rising-edge clear.
- Simultaneous tick and enable fall: the fall wins, and the tick is ignored.
- overrun_o clears only on reset or on enable_i rising.

Test Plan:
- Reset for 3 cycles, then idle → data_ready_o = 0, both samples = 0x8000, overrun_o = 0.
- enable = 1, div = 9, freq = 0x400000, amp = 0xFFFF, busy = 0:
  - Strobes every 10 cycles; the first arrives 13 cycles after the enable edge.
  - sample_a_o sequence: 0x8064, 0xFFFE, 0x7F9B, 0x0001, repeating.
  - sample_b_o sequence: 0x7F9C, 0x0002, 0x8065, 0xFFFF.
  - sample_cnt_o = 4 after 4 strobes.
- Same setup, amp = 0x8000 → second sample s = 16383, sample_a_o = 0xBFFF, sample_b_o = 0x4001.
- Hold dac_busy_i = 1 across the 2nd tick:
  - No strobe for that tick and overrun_o = 1.
  - The next strobe carries the q2 value 0x7F9B, confirming phase continuity.
- Drop enable_i while busy = 1 for 5 cycles → no strobe until busy = 0, then one strobe with both samples = 0x8000, then IDLE.
- Assert reset mid-SCALE → no strobe follows, outputs return to 0x8000, sample_cnt_o = 0.
